if_fetch_responder: RTL

Instruction-side responder that serves the fetch stage's `if_rdata_valid`/`if_rdata` pair. It holds a one-entry, 8-byte line buffer tagged by address. A hit returns the 32-bit instruction combinationally. A miss issues a single-beat read on an AXI-style AR/R channel toward memory. It sits between the PC/fetch stage and the memory interconnect, and is the producer of the signals whose absence raises the fetch-stage stall.

---
 rtl/if_fetch_responder_pkg.sv | 17 +
 rtl/if_fetch_responder.sv | 96 +++++++++
 2 files changed

// File: rtl/if_fetch_responder_pkg.sv
// rtl/if_fetch_responder_pkg.sv - widths, constants and state encoding for the fetch responder
package if_fetch_responder_pkg;

    localparam int XLEN_BUS = 64;
    localparam int INST_LEN = 32;
    localparam int LINE_TAG_W = XLEN_BUS - 3;

    localparam logic [INST_LEN-1:0] INST_NOP      = 32'h0000_0013;
    localparam logic [1:0]          AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IFR_IDLE = 2'd0,
        IFR_AR   = 2'd1,
        IFR_R    = 2'd2
    } ifr_state_e;

endpackage

// File: rtl/if_fetch_responder.sv
// rtl/if_fetch_responder.sv - one-line instruction buffer serving fetch, refilled over an AR/R read channel
module if_fetch_responder
    import if_fetch_responder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN_BUS-1:0] inst_addr_i,
    input  logic                fence_i_i,
    output logic                if_rdata_valid_o,
    output logic [XLEN_BUS-1:0] if_rdata_o,
    output logic                if_access_fault_o,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,
    output logic [XLEN_BUS-1:0] ar_addr_o,
    input  logic                r_valid_i,
    output logic                r_ready_o,
    input  logic [63:0]         r_data_i,
    input  logic [1:0]          r_resp_i
);

    ifr_state_e              state_q, state_d;
    logic [LINE_TAG_W-1:0]   req_line;
    logic                    buf_valid;
    logic [LINE_TAG_W-1:0]   buf_tag;
    logic [63:0]             buf_data;
    logic                    buf_err;
    logic                    drop;
    logic                    hit;
    logic                    beat_done;
    logic [INST_LEN-1:0]     inst_word;
    logic                    unused_addr_lsbs;

    assign hit       = buf_valid && (buf_tag == inst_addr_i[XLEN_BUS-1:3]);
    assign beat_done = (state_q == IFR_R) && r_valid_i;
    assign inst_word = inst_addr_i[2] ? buf_data[63:32] : buf_data[31:0];
    // Alignment is the fetch stage's concern; only bit 2 selects the half.
    assign unused_addr_lsbs = ^inst_addr_i[1:0];

    assign if_rdata_valid_o  = hit;
    assign if_access_fault_o = hit && buf_err;
    assign if_rdata_o = {{(XLEN_BUS-INST_LEN){1'b0}}, (hit && !buf_err) ? inst_word : INST_NOP};

    always_comb begin
        state_d    = state_q;
        ar_valid_o = 1'b0;
        r_ready_o  = 1'b0;
        ar_addr_o  = '0;
        case (state_q)
            IFR_IDLE: begin
                if (!hit && !fence_i_i) state_d = IFR_AR;
            end
            IFR_AR: begin
                ar_valid_o = 1'b1;
                ar_addr_o  = {req_line, 3'b000};
                if (ar_ready_i) state_d = IFR_R;
            end
            IFR_R: begin
                r_ready_o = 1'b1;
                if (r_valid_i) state_d = IFR_IDLE;
            end
            default: state_d = IFR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IFR_IDLE;
            req_line  <= '0;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            buf_err   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IFR_IDLE && !hit && !fence_i_i)
                req_line <= inst_addr_i[XLEN_BUS-1:3];

            // A fence seen at any point of an outstanding refill poisons its beat.
            if (beat_done)
                drop <= 1'b0;
            else if (fence_i_i && state_q != IFR_IDLE)
                drop <= 1'b1;

            if (beat_done) begin
                buf_tag   <= req_line;
                buf_data  <= r_data_i;
                buf_err   <= (r_resp_i != AXI_RESP_OKAY);
                buf_valid <= !(drop || fence_i_i);
            end
            if (fence_i_i)
                buf_valid <= 1'b0;
        end
    end

endmodule
